// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide unit and the instruction decoder.
// Contents:
//   op_e      - 2-bit divide opcode (DIV, DIVU, REM, REMU)
//   state_e   - divider FSM state encoding (IDLE, CALC, DONE)
//   helpers   - opcode classification and conditional two's-complement negate
package rv32m_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned XLEN  = 32;
    localparam logic [5:0]  LAST_STEP = 6'd31;

    function automatic logic op_is_signed(input logic [1:0] o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/rv32m_div.sv
// Iterative RV32M divider: one restoring shift-subtract step per cycle.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - request a division (sampled only in IDLE)
//   op          - DIV / DIVU / REM / REMU
//   a, b        - dividend (rs1), divisor (rs2)
//   flush       - abort any operation in flight; wins over start
//   busy        - high while an accepted operation is being calculated
//   valid       - one-cycle pulse (DONE state) marking result valid
//   result      - quotient or remainder; held until the next completion
//   state       - FSM state, exported for observation
// Handshake: start is taken only in IDLE with flush low. valid is high for
// exactly one cycle (DONE) and result is updated on the edge entering DONE.
// Starts seen in CALC or DONE are dropped; the requester must hold start
// until it observes busy or valid.
module rv32m_div
    import rv32m_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result,
    output state_e      state
);

    state_e      state_q, state_d;
    logic [5:0]  count;
    logic        is_rem_q, neg_quo_q, neg_rem_q;
    logic [31:0] divisor_q;
    logic [63:0] rq_q;          // {partial remainder, dividend/quotient}
    logic [31:0] result_q;

    // Operand decode at capture time
    logic        in_signed, in_rem, div_zero, ovf, special;
    logic [31:0] a_mag, b_mag, special_res;

    assign in_signed   = op_is_signed(op);
    assign in_rem      = op_is_rem(op);
    assign a_mag       = neg_if(in_signed & a[31], a);
    assign b_mag       = neg_if(in_signed & b[31], b);
    assign div_zero    = (b == 32'd0);
    assign ovf         = in_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign special     = div_zero || ovf;
    assign special_res = div_zero ? (in_rem ? a : 32'hFFFF_FFFF)
                                  : (in_rem ? 32'd0 : 32'h8000_0000);

    // One restoring step. The 33-bit difference's MSB is the borrow: set
    // means the shifted remainder was smaller than the divisor.
    logic [32:0] rem_sh, diff;
    logic        q_bit;
    logic [63:0] rq_next;
    logic [31:0] calc_res;

    assign rem_sh   = {rq_q[63:32], rq_q[31]};
    assign diff     = rem_sh - {1'b0, divisor_q};
    assign q_bit    = ~diff[32];
    assign rq_next  = {(q_bit ? diff[31:0] : rem_sh[31:0]), rq_q[30:0], q_bit};
    assign calc_res = is_rem_q ? neg_if(neg_rem_q, rq_next[63:32])
                               : neg_if(neg_quo_q, rq_next[31:0]);

    logic accept, step, last_step;

    assign accept    = (state_q == ST_IDLE) && start && !flush;
    assign step      = (state_q == ST_CALC) && !flush;
    assign last_step = (count == LAST_STEP);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state and status outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        valid   = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                busy = 1'b1;
                if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                valid   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 6'd0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divisor_q <= 32'd0;
            rq_q      <= 64'd0;
            result_q  <= 32'd0;
        end else if (accept) begin
            count     <= 6'd0;
            is_rem_q  <= in_rem;
            neg_quo_q <= in_signed & (a[31] ^ b[31]);
            neg_rem_q <= in_signed & a[31];
            divisor_q <= b_mag;
            rq_q      <= {32'd0, a_mag};
            if (special) result_q <= special_res;
        end else if (step) begin
            rq_q  <= rq_next;
            count <= count + 6'd1;
            if (last_step) result_q <= calc_res;
        end
    end

    assign result = result_q;
    assign state  = state_q;

endmodule
